// File: rtl/approx_mul_seq_ctrl_pkg.sv
// Shared definitions for the approximate sequential 8x8 multiplier.
//   - state_e        : controller FSM states
//   - MODE_*         : 2-bit per-partial-product unit selectors
//   - SHIFT_*        : accumulation shift for each partial product
//   - mul4_*         : 4x4 multiplier units (exact and two truncating variants)
package approx_mul_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLl,
    StLh,
    StHl,
    StHh,
    StDone
  } state_e;

  localparam logic [1:0] MODE_EXACT = 2'b00;
  localparam logic [1:0] MODE_AP1   = 2'b01;
  localparam logic [1:0] MODE_AP3   = 2'b10;

  localparam int unsigned SHIFT_LL  = 0;
  localparam int unsigned SHIFT_MID = 4;  // LH and HL
  localparam int unsigned SHIFT_HH  = 8;

  function automatic logic [7:0] mul4_exact(input logic [3:0] x, input logic [3:0] y);
    return {4'b0000, x} * {4'b0000, y};
  endfunction

  // ap1: exact product with its least significant bit forced to zero.
  function automatic logic [7:0] mul4_ap1(input logic [3:0] x, input logic [3:0] y);
    return mul4_exact(x, y) & 8'hFE;
  endfunction

  // ap3: exact product with its three least significant bits forced to zero.
  function automatic logic [7:0] mul4_ap3(input logic [3:0] x, input logic [3:0] y);
    return mul4_exact(x, y) & 8'hF8;
  endfunction

endpackage

// File: rtl/pp4_sel.sv
// Mode-selectable 4x4 partial-product unit.
// Ports:
//   i_mode [1:0] : MODE_EXACT / MODE_AP1 / MODE_AP3 (11 behaves as exact)
//   i_a, i_b [3:0] : nibble operands
//   o_pp [7:0]   : selected partial product
module pp4_sel
  import approx_mul_seq_ctrl_pkg::*;
(
  input  logic [1:0] i_mode,
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic [7:0] o_pp
);

  logic [7:0] w_exact;
  logic [7:0] w_ap1;
  logic [7:0] w_ap3;

  assign w_exact = mul4_exact(i_a, i_b);
  assign w_ap1   = mul4_ap1(i_a, i_b);
  assign w_ap3   = mul4_ap3(i_a, i_b);

  always_comb begin
    o_pp = w_exact;
    case (i_mode)
      MODE_AP1: o_pp = w_ap1;
      MODE_AP3: o_pp = w_ap3;
      default:  o_pp = w_exact;
    endcase
  end

endmodule

// File: rtl/approx_mul_seq_ctrl.sv
// Sequential 8x8 multiplier built from four 4x4 partial products on one shared,
// per-product configurable (exact / approximate) unit.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : operand handshake (a, b latched on accept)
//   cfg_we/cfg_wdata    : mode register write {hh,hl,lh,ll}; dropped while busy
//   cfg, cfg_drop       : current mode, one-cycle pulse on a dropped write
//   out_valid/out_ready : result handshake, prod held until next result
//   busy, done_cnt      : not idle, count of completed output handshakes
module approx_mul_seq_ctrl
  import approx_mul_seq_ctrl_pkg::*;
#(
  parameter logic [7:0] CFG_RESET = 8'b01_01_10_10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic        cfg_we,
  input  logic [7:0]  cfg_wdata,
  output logic [7:0]  cfg,
  output logic        cfg_drop,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] prod,
  output logic        busy,
  output logic [15:0] done_cnt
);

  state_e      r_state;
  logic [7:0]  r_a;
  logic [7:0]  r_b;
  logic [7:0]  r_op_cfg;  // cfg snapshot taken at accept, used for the whole operation
  logic [15:0] r_acc;
  logic [7:0]  r_cfg;
  logic        r_cfg_drop;
  logic        r_out_valid;
  logic [15:0] r_prod;
  logic        r_busy;
  logic        r_in_ready;
  logic [15:0] r_done_cnt;

  logic [1:0]  w_mode;
  logic [3:0]  w_na;
  logic [3:0]  w_nb;
  logic [3:0]  w_shift;
  logic [7:0]  w_pp;
  logic [15:0] w_pp_ext;

  // Route the nibbles and mode field of the active partial product to the shared unit.
  always_comb begin
    w_mode  = r_op_cfg[1:0];
    w_na    = r_a[3:0];
    w_nb    = r_b[3:0];
    w_shift = 4'(SHIFT_LL);
    case (r_state)
      StLh: begin
        w_mode  = r_op_cfg[3:2];
        w_nb    = r_b[7:4];
        w_shift = 4'(SHIFT_MID);
      end
      StHl: begin
        w_mode  = r_op_cfg[5:4];
        w_na    = r_a[7:4];
        w_shift = 4'(SHIFT_MID);
      end
      StHh: begin
        w_mode  = r_op_cfg[7:6];
        w_na    = r_a[7:4];
        w_nb    = r_b[7:4];
        w_shift = 4'(SHIFT_HH);
      end
      default: ;
    endcase
  end

  pp4_sel u_pp4_sel (
    .i_mode (w_mode),
    .i_a    (w_na),
    .i_b    (w_nb),
    .o_pp   (w_pp)
  );

  assign w_pp_ext = {8'h00, w_pp} << w_shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_a         <= 8'h00;
      r_b         <= 8'h00;
      r_op_cfg    <= 8'h00;
      r_acc       <= 16'h0000;
      r_cfg       <= CFG_RESET;
      r_cfg_drop  <= 1'b0;
      r_out_valid <= 1'b0;
      r_prod      <= 16'h0000;
      r_busy      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_done_cnt  <= 16'h0000;
    end else begin
      r_cfg_drop <= cfg_we & r_busy;
      if (cfg_we && !r_busy) begin
        r_cfg <= cfg_wdata;
      end

      case (r_state)
        StIdle: begin
          r_in_ready <= 1'b1;
          // r_in_ready gates accept so nothing is taken on the first edge after reset.
          if (in_valid && r_in_ready) begin
            r_a        <= a;
            r_b        <= b;
            r_op_cfg   <= r_cfg;
            r_acc      <= 16'h0000;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= StLl;
          end
        end
        StLl: begin
          r_acc   <= r_acc + w_pp_ext;
          r_state <= StLh;
        end
        StLh: begin
          r_acc   <= r_acc + w_pp_ext;
          r_state <= StHl;
        end
        StHl: begin
          r_acc   <= r_acc + w_pp_ext;
          r_state <= StHh;
        end
        StHh: begin
          r_acc   <= r_acc + w_pp_ext;
          r_state <= StDone;
        end
        StDone: begin
          if (!r_out_valid) begin
            r_prod      <= r_acc;
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_done_cnt  <= r_done_cnt + 16'd1;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign cfg       = r_cfg;
  assign cfg_drop  = r_cfg_drop;
  assign out_valid = r_out_valid;
  assign prod      = r_prod;
  assign busy      = r_busy;
  assign done_cnt  = r_done_cnt;

endmodule
